// File: rtl/maze_navigator.sv
// maze_navigator: player-movement stage behind the maze carver.
// Turns button edges into single-cell moves, validates them against the
// carved cell map, counts accepted moves and flags arrival at the goal.
// Optional build macro: AUTO_REPEAT_EN (held-button repeat every REPEAT_CYCLES).
module maze_navigator #(
    parameter int          MAZE_COLS     = 64,
    parameter int          MAZE_ROWS     = 64,
    parameter logic [23:0] REPEAT_CYCLES = 24'd5_000_000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             maze_valid,
    input  logic [2*MAZE_COLS*MAZE_ROWS-1:0] maze_data,
    input  logic [5:0]                       goal_x,
    input  logic [5:0]                       goal_y,
    input  logic                             btn_up,
    input  logic                             btn_down,
    input  logic                             btn_left,
    input  logic                             btn_right,
    output logic [5:0]                       player_x,
    output logic [5:0]                       player_y,
    output logic [15:0]                      move_count,
    output logic                             bump,
    output logic                             won
);

    localparam int         IW    = $clog2(2 * MAZE_COLS * MAZE_ROWS);
    localparam logic [5:0] MAX_X = 6'(MAZE_COLS - 1);
    localparam logic [5:0] MAX_Y = 6'(MAZE_ROWS - 1);
    localparam logic [1:0] PATH  = 2'b01;

    typedef enum logic [1:0] {IDLE, PLAY, CHECK, WIN} state_t;

    state_t      state, next_state;
    logic [3:0]  btn_q, btn_prev;       // {up, down, left, right}
    logic [3:0]  btn_edge, req;
    logic [5:0]  goal_xq, goal_yq;
    logic [5:0]  tgt_x, tgt_y;
    logic [5:0]  nx, ny;
    logic        oob, req_any, at_goal, cell_path;
    logic [IW-1:0] cell_idx;
    logic [15:0] cnt_q;
    logic        load_tgt, take_move, set_bump;

    assign btn_edge   = btn_q & ~btn_prev;
    assign at_goal    = (player_x == goal_xq) && (player_y == goal_yq);
    assign move_count = cnt_q;

`ifdef AUTO_REPEAT_EN
    logic [23:0] rpt_cnt;
    logic        rpt_fire;

    assign rpt_fire = (state == PLAY) && (btn_q != 4'b0) && (rpt_cnt == REPEAT_CYCLES - 24'd1);

    // Hold timer: restarts on release, on a fresh edge, or outside the play loop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rpt_cnt <= 24'd0;
        else if ((state != PLAY && state != CHECK) || btn_q == 4'b0 || btn_edge != 4'b0 || rpt_fire)
            rpt_cnt <= 24'd0;
        else
            rpt_cnt <= rpt_cnt + 24'd1;
    end

    assign req = btn_edge | (rpt_fire ? btn_q : 4'b0);
`else
    assign req = btn_edge;
`endif

    // Pick one request by priority (up > down > left > right) and form its target
    always_comb begin
        req_any = |req;
        oob     = 1'b0;
        nx      = player_x;
        ny      = player_y;
        if (req[3]) begin
            if (player_y == 6'd0) oob = 1'b1; else ny = player_y - 6'd1;
        end else if (req[2]) begin
            if (player_y == MAX_Y) oob = 1'b1; else ny = player_y + 6'd1;
        end else if (req[1]) begin
            if (player_x == 6'd0) oob = 1'b1; else nx = player_x - 6'd1;
        end else if (req[0]) begin
            if (player_x == MAX_X) oob = 1'b1; else nx = player_x + 6'd1;
        end
    end

    // Look up the registered target cell in the map
    always_comb begin
        cell_idx  = IW'((int'(tgt_y) * MAZE_COLS + int'(tgt_x)) * 2);
        cell_path = (maze_data[cell_idx +: 2] == PATH);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; losing the map forces IDLE from anywhere
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (maze_valid) next_state = PLAY;
            PLAY:  if (at_goal) next_state = WIN;
                   else if (req_any && !oob) next_state = CHECK;
            CHECK: next_state = (cell_path && tgt_x == goal_xq && tgt_y == goal_yq) ? WIN : PLAY;
            WIN:   next_state = WIN;
            default: next_state = IDLE;
        endcase
        if (!maze_valid) next_state = IDLE;
    end

    // Output/control decode from the current state
    always_comb begin
        load_tgt  = (state == PLAY) && (next_state == CHECK);
        take_move = maze_valid && (state == CHECK) && cell_path;
        set_bump  = maze_valid && (((state == PLAY) && !at_goal && req_any && oob) ||
                                   ((state == CHECK) && !cell_path));
        won       = (state == WIN);
    end

    // Datapath: button history, goal latch, target, position and move counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_q    <= 4'b0;
            btn_prev <= 4'b0;
            goal_xq  <= 6'd0;
            goal_yq  <= 6'd0;
            tgt_x    <= 6'd0;
            tgt_y    <= 6'd0;
            player_x <= 6'd0;
            player_y <= 6'd0;
            cnt_q    <= 16'd0;
            bump     <= 1'b0;
        end else begin
            btn_prev <= btn_q;
            btn_q    <= {btn_up, btn_down, btn_left, btn_right};
            bump     <= set_bump;
            // Goal tracks the inputs while idle, so it holds the value seen on entry to PLAY
            if (state == IDLE) begin
                goal_xq <= goal_x;
                goal_yq <= goal_y;
            end
            if (load_tgt) begin
                tgt_x <= nx;
                tgt_y <= ny;
            end
            if (next_state == IDLE) begin
                player_x <= 6'd0;
                player_y <= 6'd0;
                cnt_q    <= 16'd0;
            end else if (take_move) begin
                player_x <= tgt_x;
                player_y <= tgt_y;
                if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_maze_navigator.sv
// tb_maze_navigator: randomized and directed checks of maze_navigator against
// a move-rule reference model (map array + player position/count/won).
`timescale 1ns/1ps
module tb_maze_navigator;

    logic          clk = 1'b0;
    logic          reset;
    logic          maze_valid;
    logic [8191:0] maze_data;
    logic [5:0]    goal_x, goal_y;
    logic          btn_up, btn_down, btn_left, btn_right;
    logic [5:0]    player_x, player_y;
    logic [15:0]   move_count;
    logic          bump, won;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [1:0]  mmap [64][64];   // [x][y]
    int          m_x, m_y, g_x, g_y;
    logic [15:0] m_cnt;
    logic        m_won;

    maze_navigator dut (
        .clk(clk), .reset(reset), .maze_valid(maze_valid), .maze_data(maze_data),
        .goal_x(goal_x), .goal_y(goal_y),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .player_x(player_x), .player_y(player_y), .move_count(move_count),
        .bump(bump), .won(won)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pack_map();
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 64; x++)
                maze_data[2*x + 128*y +: 2] = mmap[x][y];
    endtask

    // Random map, PATH-heavy, with fixed cells near the origin for directed tests
    task automatic gen_map();
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 64; x++)
                mmap[x][y] = ($urandom_range(0, 2) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
        for (int x = 0; x < 4; x++) mmap[x][0] = 2'b01;
        mmap[0][1] = 2'b11;
        mmap[1][1] = 2'b01;
        mmap[2][1] = 2'b01;
        mmap[63][63] = 2'b11;
        pack_map();
    endtask

    task automatic restart(input int gx, input int gy);
        maze_valid = 1'b0;
        step();
        goal_x = 6'(gx);
        goal_y = 6'(gy);
        maze_valid = 1'b1;
        step();
        g_x = gx; g_y = gy;
        m_x = 0; m_y = 0; m_cnt = 16'd0;
        m_won = (gx == 0 && gy == 0);
    endtask

    // Apply a one-cycle press and capture {bump@+2, bump@+3, bump@+4, x, y, count, won@+3}
    task automatic do_press(input logic [3:0] b, output logic [31:0] obs);
        logic b2, b3, b4;
        logic [5:0] ox, oy;
        logic [15:0] oc;
        logic ow;
        {btn_up, btn_down, btn_left, btn_right} = b;
        step();
        {btn_up, btn_down, btn_left, btn_right} = 4'b0;
        step();
        b2 = bump;
        step();
        b3 = bump; ox = player_x; oy = player_y; oc = move_count; ow = won;
        step();
        b4 = bump;
        obs = {b2, b3, b4, ox, oy, oc, ow};
    endtask

    // Move rules: one move by priority, bounds reject early, non-PATH rejects after lookup
    task automatic model_press(input logic [3:0] b, output logic [31:0] exp_v);
        int tx, ty;
        logic e2, e3;
        e2 = 1'b0; e3 = 1'b0;
        tx = m_x; ty = m_y;
        if (!m_won && b != 4'b0) begin
            if (b[3]) ty = ty - 1;
            else if (b[2]) ty = ty + 1;
            else if (b[1]) tx = tx - 1;
            else tx = tx + 1;
            if (tx < 0 || tx > 63 || ty < 0 || ty > 63) e2 = 1'b1;
            else if (mmap[tx][ty] == 2'b01) begin
                m_x = tx; m_y = ty;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (m_x == g_x && m_y == g_y) m_won = 1'b1;
            end else e3 = 1'b1;
        end
        exp_v = {e2, e3, 1'b0, 6'(m_x), 6'(m_y), m_cnt, m_won};
    endtask

    task automatic test_reset();
        reset = 1'b0;
        maze_valid = 1'b1;
        goal_x = 6'd63; goal_y = 6'd63;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0;
        gen_map();
        repeat (3) step();
        checks++;
        if ({player_x, player_y, move_count, bump, won} !== 30'd0) begin
            errors++; $display("FAIL reset_hold: got %h want 0", {player_x, player_y, move_count, bump, won});
        end
        reset = 1'b1;
        step();
        checks++;
        if ({player_x, player_y, move_count, bump, won} !== 30'd0) begin
            errors++; $display("FAIL reset_release: got %h want 0", {player_x, player_y, move_count, bump, won});
        end
        g_x = 63; g_y = 63; m_x = 0; m_y = 0; m_cnt = 16'd0; m_won = 1'b0;
    endtask

    task automatic test_basic_moves();
        logic [31:0] obs, exp_v;
        // Block entered PLAY on the first edge after reset release; right should be accepted
        do_press(4'b0001, obs); model_press(4'b0001, exp_v);
        checks++;
        if (obs !== exp_v || player_x !== 6'd1 || player_y !== 6'd0 || move_count !== 16'd1) begin
            errors++; $display("FAIL move_right: got %h want %h", obs, exp_v);
        end
        do_press(4'b0010, obs); model_press(4'b0010, exp_v);
        checks++;
        if (obs !== exp_v || player_x !== 6'd0 || move_count !== 16'd2) begin
            errors++; $display("FAIL move_left: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_bump();
        logic [31:0] obs, exp_v;
        do_press(4'b0100, obs); model_press(4'b0100, exp_v);   // down onto WALL
        checks++;
        if (obs !== exp_v || obs[30:29] !== 2'b10) begin
            errors++; $display("FAIL bump_wall: got %h want %h", obs, exp_v);
        end
        do_press(4'b1000, obs); model_press(4'b1000, exp_v);   // up off the map
        checks++;
        if (obs !== exp_v || obs[31:29] !== 3'b100) begin
            errors++; $display("FAIL bump_oob: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_priority_hold();
        logic [31:0] obs, exp_v;
        logic [15:0] c0;
        do_press(4'b0001, obs); model_press(4'b0001, exp_v);
        do_press(4'b0100, obs); model_press(4'b0100, exp_v);
        checks++;
        if (obs !== exp_v || player_x !== 6'd1 || player_y !== 6'd1) begin
            errors++; $display("FAIL prio_setup: got %h want %h", obs, exp_v);
        end
        do_press(4'b1001, obs); model_press(4'b1001, exp_v);   // up + right together
        checks++;
        if (obs !== exp_v || player_x !== 6'd1 || player_y !== 6'd0) begin
            errors++; $display("FAIL prio_up_right: got %h want %h", obs, exp_v);
        end
        c0 = move_count;
        btn_right = 1'b1;
        repeat (100) step();
        btn_right = 1'b0;
        repeat (3) step();
`ifndef AUTO_REPEAT_EN
        checks++;
        if (player_x !== 6'd2 || player_y !== 6'd0 || move_count !== c0 + 16'd1) begin
            errors++; $display("FAIL hold_once: got x=%0d cnt=%0d want x=2 cnt=%0d", player_x, move_count, c0 + 16'd1);
        end
`endif
    endtask

    task automatic test_goal();
        logic [31:0] obs, exp_v;
        restart(3, 0);
        for (int i = 0; i < 3; i++) begin
            do_press(4'b0001, obs); model_press(4'b0001, exp_v);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL goal_step%0d: got %h want %h", i, obs, exp_v);
            end
        end
        checks++;
        if (won !== 1'b1 || player_x !== 6'd3) begin
            errors++; $display("FAIL goal_won: got won=%b x=%0d want won=1 x=3", won, player_x);
        end
        do_press(4'b0010, obs); model_press(4'b0010, exp_v);
        checks++;
        if (obs !== exp_v || player_x !== 6'd3 || move_count !== 16'd3) begin
            errors++; $display("FAIL goal_frozen: got %h want %h", obs, exp_v);
        end
        maze_valid = 1'b0;
        step();
        checks++;
        if ({won, player_x, player_y, move_count} !== 29'd0) begin
            errors++; $display("FAIL goal_drop_valid: got %h want 0", {won, player_x, player_y, move_count});
        end
    endtask

    task automatic test_goal_origin();
        logic [31:0] obs, exp_v;
        restart(0, 0);
        step();
        checks++;
        if (won !== 1'b1) begin
            errors++; $display("FAIL origin_won: got %b want 1", won);
        end
        do_press(4'b0001, obs); model_press(4'b0001, exp_v);
        checks++;
        if (obs !== exp_v || player_x !== 6'd0) begin
            errors++; $display("FAIL origin_frozen: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid_check();
        logic [31:0] obs, exp_v;
        restart(63, 63);
        do_press(4'b0001, obs); model_press(4'b0001, exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL midchk_setup: got %h want %h", obs, exp_v);
        end
        btn_left = 1'b1;
        step();
        btn_left = 1'b0;
        step();                 // block is now in CHECK
        reset = 1'b0;
        #1;
        checks++;
        if ({player_x, player_y, move_count, bump, won} !== 30'd0) begin
            errors++; $display("FAIL midchk_reset: got %h want 0", {player_x, player_y, move_count, bump, won});
        end
        @(negedge clk);
        reset = 1'b1;
        step();
    endtask

    task automatic test_saturation();
        logic [31:0] obs, exp_v;
        logic [3:0]  seq [3];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0001;
        restart(63, 63);
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        m_cnt = 16'hFFFE;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            do_press(seq[i], obs); model_press(seq[i], exp_v);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL sat_move%0d: got %h want %h", i, obs, exp_v);
            end
        end
        checks++;
        if (move_count !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold: got %h want ffff", move_count);
        end
    endtask

    task automatic test_random();
        logic [31:0] obs, exp_v;
        logic [3:0]  b;
        for (int r = 0; r < 4; r++) begin
            maze_valid = 1'b0;
            gen_map();
            restart($urandom_range(1, 6), $urandom_range(1, 6));
            for (int i = 0; i < 80; i++) begin
                b = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'(1 << $urandom_range(0, 3));
                do_press(b, obs); model_press(b, exp_v);
                checks++;
                if (obs !== exp_v) begin
                    errors++; $display("FAIL rand_r%0d_i%0d btn=%b: got %h want %h", r, i, b, obs, exp_v);
                end
            end
        end
    endtask

    initial begin
        maze_data = '0;
        test_reset();
        test_basic_moves();
        test_bump();
        test_priority_hold();
        test_goal();
        test_goal_origin();
        test_reset_mid_check();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
